// File: rtl/slc3_pkg.sv
// Shared opcode constants, controller state encoding and mux-select codes for
// the SLC-3 sequencer.
package slc3_pkg;

  localparam logic [3:0] op_BR  = 4'b0000;
  localparam logic [3:0] op_ADD = 4'b0001;
  localparam logic [3:0] op_LD  = 4'b0010;
  localparam logic [3:0] op_ST  = 4'b0011;
  localparam logic [3:0] op_JSR = 4'b0100;
  localparam logic [3:0] op_AND = 4'b0101;
  localparam logic [3:0] op_LDR = 4'b0110;
  localparam logic [3:0] op_STR = 4'b0111;
  localparam logic [3:0] op_NOT = 4'b1001;
  localparam logic [3:0] op_JMP = 4'b1100;
  localparam logic [3:0] op_PSE = 4'b1101;
  localparam logic [3:0] op_LEA = 4'b1110;

  typedef enum logic [4:0] {
    S_HALTED, S_FETCH, S_MEM_RD, S_MEM_WR, S_DECODE_IR, S_DECODE,
    S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN, S_JMP, S_JSR1, S_JSR2, S_LEA,
    S_LD_ADDR, S_LDR_ADDR, S_ST_ADDR, S_STR_ADDR, S_ST_DATA, S_LOAD_WB,
    S_PAUSE1, S_PAUSE2
  } state_t;

  localparam logic [1:0] PCMUX_BUS  = 2'b00;
  localparam logic [1:0] PCMUX_ADDR = 2'b01;
  localparam logic [1:0] PCMUX_PC1  = 2'b10;

  localparam logic [1:0] ADDR2_OFF11 = 2'b00;
  localparam logic [1:0] ADDR2_OFF9  = 2'b01;
  localparam logic [1:0] ADDR2_OFF6  = 2'b10;
  localparam logic [1:0] ADDR2_ZERO  = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

endpackage

// File: rtl/slc3_wait_ctr.sv
// Loadable down-counter with zero flag; paces the SRAM read/write states.
module slc3_wait_ctr
  import slc3_pkg::*;
#(
  parameter int WCNT_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load_i,
  input  logic              dec_i,
  input  logic [WCNT_W-1:0] val_i,
  output logic              zero_o
);

  logic [WCNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - WCNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/slc3_ctrl_fsm.sv
// SLC-3 fetch/decode/execute sequencer with counter-paced SRAM access.
// Optional pause instruction (opcode 1101) enabled by defining SLC3_PAUSE_EN.
module slc3_ctrl_fsm
  import slc3_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int WCNT_W   = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
  output logic       GatePC, GateMDR, GateALU, GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE, Mem_UB, Mem_LB,
  output logic       Mem_OE, Mem_WE,
  output logic       Instr_done
);

  localparam logic [WCNT_W-1:0] WAIT_LD = WCNT_W'(MEM_WAIT - 1);

  state_t state_q, state_d;
  logic   ret_q, ret_d;   // 0: read feeds DECODE_IR, 1: read feeds LOAD_WB
  logic   ctr_load, ctr_dec, ctr_zero;

`ifndef SLC3_PAUSE_EN
  logic unused_continue;
  assign unused_continue = Continue;
`endif

  assign Mem_CE = 1'b0;
  assign Mem_UB = 1'b0;
  assign Mem_LB = 1'b0;

  slc3_wait_ctr #(.WCNT_W(WCNT_W)) u_wait (
    .Clk    (Clk),
    .Reset  (Reset),
    .load_i (ctr_load),
    .dec_i  (ctr_dec),
    .val_i  (WAIT_LD),
    .zero_o (ctr_zero)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_HALTED;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = '0;
    {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
    PCMUX = PCMUX_BUS;
    {DRMUX, SR1MUX, SR2MUX, ADDR1MUX} = '0;
    ADDR2MUX   = ADDR2_OFF11;
    ALUK       = ALUK_ADD;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    Instr_done = 1'b0;

    case (state_q)
      S_HALTED: if (Run) state_d = S_FETCH;
      S_FETCH: begin
        GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = PCMUX_PC1;
        ret_d = 1'b0; ctr_load = 1'b1; state_d = S_MEM_RD;
      end
      S_MEM_RD: begin
        Mem_OE = 1'b0; ctr_dec = 1'b1;
        if (ctr_zero) begin
          LD_MDR  = 1'b1;
          state_d = ret_q ? S_LOAD_WB : S_DECODE_IR;
        end
      end
      S_MEM_WR: begin
        Mem_WE = 1'b0; ctr_dec = 1'b1;
        if (ctr_zero) begin
          Instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_DECODE_IR: begin
        GateMDR = 1'b1; LD_IR = 1'b1; state_d = S_DECODE;
      end
      S_DECODE: begin
        LD_BEN = 1'b1;
        case (Opcode)
          op_ADD: state_d = S_ADD;
          op_AND: state_d = S_AND;
          op_NOT: state_d = S_NOT;
          op_BR:  state_d = S_BR;
          op_JMP: state_d = S_JMP;
          op_JSR: state_d = S_JSR1;
          op_LEA: state_d = S_LEA;
          op_LD:  state_d = S_LD_ADDR;
          op_LDR: state_d = S_LDR_ADDR;
          op_ST:  state_d = S_ST_ADDR;
          op_STR: state_d = S_STR_ADDR;
`ifdef SLC3_PAUSE_EN
          op_PSE: state_d = S_PAUSE1;
`endif
          default: begin
            Instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_ADD, S_AND, S_NOT: begin
        SR1MUX = 1'b1; DRMUX = 1'b1; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        SR2MUX = ~IR_5;
        if (state_q == S_AND)      ALUK = ALUK_AND;
        else if (state_q == S_NOT) ALUK = ALUK_NOT;
        Instr_done = 1'b1; state_d = S_FETCH;
      end
      S_BR: begin
        if (BEN) state_d = S_BR_TAKEN;
        else begin
          Instr_done = 1'b1; state_d = S_FETCH;
        end
      end
      S_BR_TAKEN: begin
        ADDR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF9; PCMUX = PCMUX_ADDR; LD_PC = 1'b1;
        Instr_done = 1'b1; state_d = S_FETCH;
      end
      S_JMP: begin
        SR1MUX = 1'b1; ADDR2MUX = ADDR2_ZERO; PCMUX = PCMUX_ADDR; LD_PC = 1'b1;
        Instr_done = 1'b1; state_d = S_FETCH;
      end
      S_JSR1: begin
        GatePC = 1'b1; LD_REG = 1'b1; state_d = S_JSR2;
      end
      S_JSR2: begin
        if (IR_11) begin
          ADDR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF11;
        end else begin
          SR1MUX = 1'b1; ADDR2MUX = ADDR2_ZERO;
        end
        PCMUX = PCMUX_ADDR; LD_PC = 1'b1;
        Instr_done = 1'b1; state_d = S_FETCH;
      end
      S_LEA: begin
        ADDR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF9; GateMARMUX = 1'b1;
        DRMUX = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        Instr_done = 1'b1; state_d = S_FETCH;
      end
      S_LD_ADDR, S_ST_ADDR: begin
        GateMARMUX = 1'b1; LD_MAR = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF9;
        if (state_q == S_LD_ADDR) begin
          ret_d = 1'b1; ctr_load = 1'b1; state_d = S_MEM_RD;
        end else state_d = S_ST_DATA;
      end
      S_LDR_ADDR, S_STR_ADDR: begin
        GateMARMUX = 1'b1; LD_MAR = 1'b1; SR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF6;
        if (state_q == S_LDR_ADDR) begin
          ret_d = 1'b1; ctr_load = 1'b1; state_d = S_MEM_RD;
        end else state_d = S_ST_DATA;
      end
      S_ST_DATA: begin
        ALUK = ALUK_PASSA; GateALU = 1'b1; LD_MDR = 1'b1;
        ctr_load = 1'b1; state_d = S_MEM_WR;
      end
      S_LOAD_WB: begin
        GateMDR = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        Instr_done = 1'b1; state_d = S_FETCH;
      end
`ifdef SLC3_PAUSE_EN
      S_PAUSE1: begin
        LD_LED = 1'b1;
        if (Continue) state_d = S_PAUSE2;
      end
      S_PAUSE2: begin
        if (!Continue) begin
          Instr_done = 1'b1; state_d = S_FETCH;
        end
      end
`endif
      default: state_d = S_HALTED;
    endcase
  end

endmodule

// File: doc/slc3_ctrl_fsm.md
Name: slc3_ctrl_fsm

Overview:
Parametrised instruction sequence/decode unit for the SLC-3 datapath. It replaces hard-coded SRAM wait states with a single counter-driven memory-access state, sized by MEM_WAIT. It extends the decoded set to ADD, AND, NOT, BR, JMP, JSR/JSRR, LD, LDR, ST, STR and LEA, and adds an instruction-retire pulse for performance counters. It sits between the IR/BEN logic and the datapath mux/load controls and the SRAM strobes.

Parameters:
MEM_WAIT, 2, SRAM access cycles per read or write (legal range 1..15).
WCNT_W, 4, wait-counter width (must hold MEM_WAIT-1).

Ports:
Clk  in  1  clock
Reset  in  1  synchronous, active-high
Run  in  1  start execution from Halted
Continue  in  1  pause release (SLC3_PAUSE_EN only)
Opcode  in  4  IR[15:12]
IR_5  in  1  imm/register select for ADD/AND
IR_11  in  1  JSR(1)/JSRR(0)
BEN  in  1  branch-enable from datapath
LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads
GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers (one-hot or none)
PCMUX  out  2  10=PC+1, 01=address adder, 00=bus
DRMUX  out  1  1=IR[11:9], 0=R7
SR1MUX  out  1  1=IR[8:6], 0=IR[11:9]
SR2MUX  out  1  1=register SR2, 0=imm5
ADDR1MUX  out  1  1=PC, 0=SR1
ADDR2MUX  out  2  00=off11, 01=off9, 10=off6, 11=zero
ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS-A
Mem_CE, Mem_UB, Mem_LB  out  1 each  tied 0
Mem_OE, Mem_WE  out  1 each  active-low strobes
Instr_done  out  1  one-cycle pulse on the final cycle of every executed instruction

Behaviour:
- Reset:
  - State goes to HALTED and the wait counter clears to 0.
  - All LD_*, Gate*, mux selects, ALUK and Instr_done are 0.
  - Mem_OE and Mem_WE are 1.
- Outputs are a Moore decode of State, plus IR_5/IR_11 where stated. Outputs not listed for a state stay at their reset value.
- HALTED: moves to FETCH when Run=1. Run is ignored in every other state.
- FETCH: GatePC, LD_MAR, LD_PC, PCMUX=10. Then MEM_RD with return target DECODE_IR.
- MEM_RD:
  - Mem_OE=0 every cycle.
  - Counter loads MEM_WAIT-1 on entry and decrements each cycle.
  - LD_MDR=1 only when the counter is 0; that is also the exit cycle.
  - Total occupancy is exactly MEM_WAIT cycles.
- MEM_WR: Mem_WE=0 for exactly MEM_WAIT cycles (same counter rule). Then goes to FETCH with Instr_done=1 on the last cycle.
- DECODE_IR: GateMDR, LD_IR. Then DECODE.
- DECODE: LD_BEN. Branches on Opcode. Undefined opcodes go to FETCH with Instr_done=1.
- ADD/AND:
  - Controls: SR1MUX=1, DRMUX=1, GateALU, LD_REG, LD_CC, SR2MUX=~IR_5, ALUK=00 (ADD) or 01 (AND).
  - One cycle, Instr_done=1.
- NOT: as ADD with ALUK=10, one cycle.
- BR:
  - Taken (BEN=1): one extra cycle with ADDR1MUX=1, ADDR2MUX=01, PCMUX=01, LD_PC.
  - Not taken: Instr_done=1 and go to FETCH.
- JMP: SR1MUX=1, ADDR1MUX=0, ADDR2MUX=11, PCMUX=01, LD_PC. One cycle.
- JSR/JSRR:
  - Cycle 1: GatePC, DRMUX=0, LD_REG.
  - Cycle 2 with IR_11=1: ADDR1MUX=1, ADDR2MUX=00.
  - Cycle 2 with IR_11=0: SR1MUX=1, ADDR1MUX=0, ADDR2MUX=11.
  - Cycle 2 always drives PCMUX=01 and LD_PC.
- LEA: ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, DRMUX=1, LD_REG, LD_CC. One cycle.
- LD/LDR:
  - Address cycle: GateMARMUX, LD_MAR. LD uses ADDR1MUX=1, ADDR2MUX=01. LDR uses SR1MUX=1, ADDR1MUX=0, ADDR2MUX=10.
  - Then MEM_RD with return target LOAD_WB.
  - LOAD_WB: GateMDR, DRMUX=1, LD_REG, LD_CC, Instr_done.
- ST/STR:
  - Address cycle as for LD/LDR.
  - Data cycle: SR1MUX=0, ALUK=11, GateALU, LD_MDR.
  - Then MEM_WR.
- Return target: a one-bit register distinguishes fetch reads from load reads; MEM_RD uses it to pick DECODE_IR or LOAD_WB.
- Mem_OE and Mem_WE are never both 0.
- Reset asserted in any state, including mid MEM_WR, returns to HALTED next edge with Mem_WE=1.
- MEM_WAIT=1: MEM_RD and MEM_WR each last one cycle, with LD_MDR on that cycle.

Optional Feature:
SLC3_PAUSE_EN
- Defined:
  - Opcode PSE (1101) goes to PAUSE1.
  - PAUSE1 holds LD_LED=1 until Continue=1, then goes to PAUSE2.
  - PAUSE2 waits for Continue=0, then goes to FETCH with Instr_done=1.
- Undefined:
  - PSE is treated as an undefined opcode.
  - LD_LED is tied 0 and Continue is unused.

Decomposition:
- Package slc3_pkg holds:
  - the opcode constants op_*;
  - the state enum;
  - the mux-select localparams (PCMUX_*, ADDR2_*, ALUK_*).
- Sub-module slc3_wait_ctr: loadable down-counter with a zero flag, parametrised by WCNT_W, used by MEM_RD and MEM_WR.

Test Plan:
- MEM_WAIT=2, Run pulse, fetch of ADD R1,R2,#5 (0x12A5) -> Mem_OE low for exactly 2 cycles. LD_MDR on the 2nd of them. LD_IR one cycle later. Execute cycle has SR2MUX=0, ALUK=00, LD_REG=1 and Instr_done=1.
- MEM_WAIT=4, LDR (0x6285) -> Mem_OE low 4 cycles. LOAD_WB has GateMDR=1, LD_REG=1, LD_CC=1. Total latency from FETCH to Instr_done is 1+4+1+1+1+4+1 = 13 cycles.
- STR with MEM_WAIT=3 -> Mem_WE low exactly 3 consecutive cycles, Mem_OE stays 1 throughout.
- BR with BEN=0 -> Instr_done in BR state with no LD_PC. BEN=1 -> extra cycle with PCMUX=01, LD_PC=1, ADDR2MUX=01.
- JSR 0x4803 (IR_11=1) -> LD_REG with DRMUX=0, then ADDR1MUX=1. JSRR (IR_11=0) -> ADDR1MUX=0, ADDR2MUX=11.
- Reset asserted on the 2nd MEM_WR cycle -> next edge State=HALTED, Mem_WE=1, all loads 0. Run re-fetches normally. With SLC3_PAUSE_EN, opcode 0xD holds LD_LED=1 until a Continue high-then-low sequence.
